pic_rw_ctrl_sync: RTL and testbench
===================================

// Module: pic_rw_ctrl_sync
// PURPOSE
//  Clocked, parametrised read/write control unit of the 8259-style PIC; sits between CPU bus and control logic.
//  Samples CPU write strobes on clk, sequences ICW1..ICW4 with an explicit FSM and decodes OCW1..OCW3.
//  Emits one-cycle command strobes plus registered data, and drives read data: IRR/ISR/IMR or poll word.
//  Adds over the previous unit: registered outputs, ICW1 re-init from any state, OCW3 read-select and poll.
// PARAMETERS
//  IRQ_W       8  width of irr/isr/imr inputs (1..8); zero-extended onto the 8-bit data bus
//  CASCADE_EN  1  0: ICW3 never requested (SNGL forced); 1: ICW3 requested when ICW1.D1=0
//  ICW4_EN     1  0: ICW4 never requested; 1: ICW4 requested when ICW1.D0=1
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      synchronous active-high reset
//  cs_n        in   1      chip select, active low (synchronous to clk)
//  rd_n        in   1      read strobe, active low
//  wr_n        in   1      write strobe, active low
//  a0          in   1      address bit 0
//  din         in   8      CPU write data
//  irr         in   IRQ_W  interrupt request register
//  isr         in   IRQ_W  in-service register
//  imr         in   IRQ_W  interrupt mask register
//  poll_word   in   8      {int_pending,4'b0,level[2:0]} from priority logic
//  dout        out  8      read data to CPU
//  read        out  1      ~rd_n & ~cs_n & wr_n (combinational)
//  data_out    out  8      registered copy of last accepted command byte
//  icw_stb     out  4      one-hot pulse, bit k-1 = ICWk accepted
//  ocw_stb     out  3      one-hot pulse, bit k-1 = OCWk accepted
//  init_done   out  1      1 when initialisation sequence complete
//  poll_ack    out  1      one-cycle pulse when a poll read finishes
// BEHAVIOUR
//  Reset: state=W_ICW1, data_out=0, icw_stb=0, ocw_stb=0, init_done=0, poll_ack=0, rsel=IRR, poll_arm=0.
//  Write accept: wr_act = ~cs_n & ~wr_n; accept on cycle where wr_act=1 and wr_act_q=0 (one per strobe).
//  Held strobe never re-accepts; accepted byte appears on data_out and strobe pulses exactly 1 cycle later.
//  FSM states: W_ICW1, W_ICW2, W_ICW3, W_ICW4, READY.
//   Any state: a0=0 & din[4]=1 -> ICW1: latch need3=CASCADE_EN&~din[1], need4=ICW4_EN&din[0];
//     icw_stb[0]; init_done<=0; -> W_ICW2. ICW1 in READY restarts initialisation.
//   W_ICW1: a0=1 or (a0=0 & din[4]=0) writes ignored, no strobe.
//   W_ICW2: a0=1 -> icw_stb[1]; -> W_ICW3 if need3, else W_ICW4 if need4, else READY.
//   W_ICW3: a0=1 -> icw_stb[2]; -> W_ICW4 if need4 else READY.  W_ICW4: a0=1 -> icw_stb[3]; -> READY.
//   W_ICW2..4 with a0=0 & din[4]=0: ignored. Entering READY sets init_done=1 same edge as last icw_stb.
//   READY: a0=1 -> OCW1 (ocw_stb[0]); a0=0,din[4:3]=00 -> OCW2 (ocw_stb[1]);
//     a0=0,din[4:3]=01,din[7]=0 -> OCW3 (ocw_stb[2]); other encodings ignored.
//  OCW3 side effects: din[1]=1 -> rsel<=din[0] (0=IRR,1=ISR), din[1]=0 keeps rsel; din[2]=1 -> poll_arm<=1.
//  Read mux (combinational on current regs): a0=1 -> imr; a0=0 & poll_arm -> poll_word;
//   else rsel ? isr : irr. IRQ_W<8 zero-extended. dout valid whenever read=1, else 8'h00.
//  Poll: on read falling (read_q=1, read=0) with poll_arm and a0 sampled 0, poll_ack pulses 1 cycle,
//   poll_arm clears. Read with a0=1 while armed does not consume poll.
//  Simultaneous rd_n & wr_n low with cs_n low: write wins, read=0, no poll consumption.
//  init_done=0: reads still served (IRR default); OCW writes ignored.
//  rst mid-sequence: returns to W_ICW1 next edge, any pending strobe dropped.
// TESTING
//  ICW1=0x13, ICW2=0x20(a0=1), ICW4=0x01 -> icw_stb 0001,0010,1000; no ICW3; init_done=1 after ICW4.
//  ICW1=0x10 then 3 a0=1 writes -> icw_stb 0001,0010,0100 then init_done=1; 3rd write no icw_stb[3].
//  READY: a0=1 0xF0 -> ocw_stb=001, data_out=F0; a0=0 0x20 -> ocw_stb=010; wr_n held 5 cycles -> 1 pulse.
//  OCW3 0x0B, irr=0x05, isr=0x80: read a0=0 -> 0x80; OCW3 0x0A -> 0x05; a0=1, imr=0x3C -> 0x3C.
//  OCW3 0x0C, poll_word=0x83: read a0=0 -> 0x83, poll_ack on release; next read -> irr.
//  ICW1 0x13 in READY -> init_done=0, OCW write then ignored; rst after ICW2 -> W_ICW1, all outputs 0.

Source files
------------

// File: rtl/pic_rw_ctrl_sync.sv
// Clocked read/write control unit of an 8259-style PIC: sequences ICW1..ICW4,
// decodes OCW1..OCW3, emits registered one-cycle command strobes and drives the read bus.
module pic_rw_ctrl_sync #(
    parameter int IRQ_W      = 8,
    parameter bit CASCADE_EN = 1'b1,
    parameter bit ICW4_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             rd_n,
    input  logic             wr_n,
    input  logic             a0,
    input  logic [7:0]       din,
    input  logic [IRQ_W-1:0] irr,
    input  logic [IRQ_W-1:0] isr,
    input  logic [IRQ_W-1:0] imr,
    input  logic [7:0]       poll_word,
    output logic [7:0]       dout,
    output logic             read,
    output logic [7:0]       data_out,
    output logic [3:0]       icw_stb,
    output logic [2:0]       ocw_stb,
    output logic             init_done,
    output logic             poll_ack
);

    typedef enum logic [2:0] {W_ICW1, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

    state_t     state, state_n;
    logic       need3, need3_n, need4, need4_n;
    logic [3:0] icw_n;
    logic [2:0] ocw_n;
    logic       done_n;
    logic       wr_act, wr_act_q, accept, load;
    logic       read_q, rd_a0_q, poll_take;
    logic       rsel, poll_arm;

    assign wr_act = ~cs_n & ~wr_n;
    assign accept = wr_act & ~wr_act_q;
    assign read   = ~rd_n & ~cs_n & wr_n;
    assign load   = (|icw_n) | (|ocw_n);
    // A write strobe that ends a read is a write, not a poll acknowledge.
    assign poll_take = read_q & ~read & poll_arm & ~rd_a0_q & ~wr_act;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        need3_n = need3;
        need4_n = need4;
        icw_n   = 4'b0000;
        ocw_n   = 3'b000;
        done_n  = init_done;
        if (accept) begin
            if (!a0 && din[4]) begin
                // ICW1 restarts initialisation from any state, including READY.
                need3_n = CASCADE_EN & ~din[1];
                need4_n = ICW4_EN & din[0];
                icw_n   = 4'b0001;
                done_n  = 1'b0;
                state_n = W_ICW2;
            end else begin
                unique case (state)
                    W_ICW2: if (a0) begin
                        icw_n   = 4'b0010;
                        state_n = need3 ? W_ICW3 : (need4 ? W_ICW4 : READY);
                    end
                    W_ICW3: if (a0) begin
                        icw_n   = 4'b0100;
                        state_n = need4 ? W_ICW4 : READY;
                    end
                    W_ICW4: if (a0) begin
                        icw_n   = 4'b1000;
                        state_n = READY;
                    end
                    READY: begin
                        if (a0)                            ocw_n = 3'b001;
                        else if (din[4:3] == 2'b00)        ocw_n = 3'b010;
                        else if (din[4:3] == 2'b01 && !din[7]) ocw_n = 3'b100;
                    end
                    default: ;
                endcase
                if (state_n == READY && state != READY) done_n = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= W_ICW1;
            need3     <= 1'b0;
            need4     <= 1'b0;
            data_out  <= 8'h00;
            icw_stb   <= 4'b0000;
            ocw_stb   <= 3'b000;
            init_done <= 1'b0;
            poll_ack  <= 1'b0;
            rsel      <= 1'b0;
            poll_arm  <= 1'b0;
            wr_act_q  <= 1'b0;
            read_q    <= 1'b0;
            rd_a0_q   <= 1'b0;
        end else begin
            state     <= state_n;
            need3     <= need3_n;
            need4     <= need4_n;
            icw_stb   <= icw_n;
            ocw_stb   <= ocw_n;
            init_done <= done_n;
            poll_ack  <= poll_take;
            wr_act_q  <= wr_act;
            read_q    <= read;
            if (read) rd_a0_q  <= a0;
            if (load) data_out <= din;
            if (ocw_n[2]) begin
                if (din[1]) rsel     <= din[0];
                if (din[2]) poll_arm <= 1'b1;
            end else if (poll_take) begin
                poll_arm <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = 8'h00;
        if (read) begin
            if (a0)            dout = 8'(imr);
            else if (poll_arm) dout = poll_word;
            else if (rsel)     dout = 8'(isr);
            else               dout = 8'(irr);
        end
    end

endmodule

// File: tb/tb_pic_rw_ctrl_sync.sv
// Self-checking bench for pic_rw_ctrl_sync: directed scenarios with literal expectations,
// then randomized bus traffic compared every cycle against a queue-based behavioural model.
module tb_pic_rw_ctrl_sync;

    logic       clk = 1'b0;
    logic       rst, cs_n, rd_n, wr_n, a0;
    logic [7:0] din, irr, isr, imr, poll_word;
    logic [7:0] dout, data_out;
    logic       read, init_done, poll_ack;
    logic [3:0] icw_stb;
    logic [2:0] ocw_stb;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    pic_rw_ctrl_sync dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
        .din(din), .irr(irr), .isr(isr), .imr(imr), .poll_word(poll_word),
        .dout(dout), .read(read), .data_out(data_out), .icw_stb(icw_stb),
        .ocw_stb(ocw_stb), .init_done(init_done), .poll_ack(poll_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: initialisation is a queue of the ICW numbers still owed.
    int         icw_q[$];
    bit         m_done, m_rsel, m_parm, m_wrq, m_rdq, m_rda0;
    logic [7:0] e_data;
    logic [3:0] e_icw;
    logic [2:0] e_ocw;
    bit         e_pack;

    always @(posedge clk) begin
        bit wr, rdv, acc;
        int k;
        wr  = !cs_n && !wr_n;
        rdv = !rd_n && !cs_n && wr_n;
        acc = wr && !m_wrq;
        if (rst) begin
            icw_q.delete();
            m_done = 0; m_rsel = 0; m_parm = 0; m_wrq = 0; m_rdq = 0; m_rda0 = 0;
            e_data = 8'h00; e_icw = 4'h0; e_ocw = 3'h0; e_pack = 0;
        end else begin
            e_icw = 4'h0; e_ocw = 3'h0; e_pack = 0;
            if (m_rdq && !rdv && m_parm && !m_rda0 && !wr) begin
                e_pack = 1; m_parm = 0;
            end
            if (acc) begin
                if (!a0 && din[4]) begin
                    icw_q.delete();
                    icw_q.push_back(2);
                    if (!din[1]) icw_q.push_back(3);
                    if (din[0])  icw_q.push_back(4);
                    e_icw = 4'b0001; e_data = din; m_done = 0;
                end else if (icw_q.size() != 0) begin
                    if (a0) begin
                        k = icw_q.pop_front();
                        e_icw  = 4'(1 << (k - 1));
                        e_data = din;
                        if (icw_q.size() == 0) m_done = 1;
                    end
                end else if (m_done) begin
                    if (a0) e_ocw = 3'b001;
                    else if (din[4:3] == 2'b00) e_ocw = 3'b010;
                    else if (din[4:3] == 2'b01 && !din[7]) begin
                        e_ocw = 3'b100;
                        if (din[1]) m_rsel = din[0];
                        if (din[2]) m_parm = 1;
                    end
                    if (e_ocw != 0) e_data = din;
                end
            end
            m_wrq = wr; m_rdq = rdv;
            if (rdv) m_rda0 = a0;
        end
    end

    always @(negedge clk) begin
        bit         e_read;
        logic [7:0] e_dout;
        if (cmp_en) begin
            e_read = !rd_n && !cs_n && wr_n;
            e_dout = !e_read ? 8'h00 : a0 ? imr : m_parm ? poll_word : m_rsel ? isr : irr;
            check("m_data_out",  data_out,  e_data);
            check("m_icw_stb",   icw_stb,   e_icw);
            check("m_ocw_stb",   ocw_stb,   e_ocw);
            check("m_init_done", init_done, m_done);
            check("m_poll_ack",  poll_ack,  e_pack);
            check("m_read",      read,      e_read);
            check("m_dout",      dout,      e_dout);
        end
    end

    task automatic idle();
        cs_n = 1; rd_n = 1; wr_n = 1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d, input logic [3:0] ei,
                      input logic [2:0] eo, input int hold);
        @(posedge clk); #1;
        cs_n = 0; wr_n = 0; rd_n = 1; a0 = a; din = d;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            check(i == 0 ? "icw_pulse" : "icw_held", icw_stb, i == 0 ? ei : 4'h0);
            check(i == 0 ? "ocw_pulse" : "ocw_held", ocw_stb, i == 0 ? eo : 3'h0);
            if (i == 0 && (ei != 0 || eo != 0)) check("data_out", data_out, d);
            #7;
        end
        idle();
    endtask

    task automatic rd(input logic a, input logic [7:0] ed, input logic epa);
        @(posedge clk); #1;
        cs_n = 0; rd_n = 0; wr_n = 1; a0 = a;
        #2 check("rd_dout", dout, ed);
        @(posedge clk); #1;
        idle();
        @(posedge clk); #2;
        check("poll_ack", poll_ack, epa);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; idle(); a0 = 0; din = 0;
        irr = 8'h05; isr = 8'h80; imr = 8'h3C; poll_word = 8'h83;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        cmp_en = 1;
        @(negedge clk);
        check("rst_data_out", data_out, 8'h00);
        check("rst_init_done", init_done, 1'b0);
        check("rst_strobes", {icw_stb, ocw_stb, poll_ack}, 8'h00);

        wr(0, 8'h13, 4'b0001, 3'b000, 1);
        wr(1, 8'h20, 4'b0010, 3'b000, 1);
        wr(1, 8'h01, 4'b1000, 3'b000, 1);
        check("done_after_icw4", init_done, 1'b1);

        wr(0, 8'h10, 4'b0001, 3'b000, 1);
        check("done_cleared", init_done, 1'b0);
        wr(1, 8'h20, 4'b0010, 3'b000, 1);
        wr(1, 8'h00, 4'b0100, 3'b000, 1);
        check("done_after_icw3", init_done, 1'b1);
        wr(1, 8'hF0, 4'b0000, 3'b001, 1);
        wr(0, 8'h20, 4'b0000, 3'b010, 1);
        wr(0, 8'h20, 4'b0000, 3'b010, 5);

        wr(0, 8'h0B, 4'b0000, 3'b100, 1);
        rd(0, 8'h80, 1'b0);
        wr(0, 8'h0A, 4'b0000, 3'b100, 1);
        rd(0, 8'h05, 1'b0);
        rd(1, 8'h3C, 1'b0);

        wr(0, 8'h0C, 4'b0000, 3'b100, 1);
        rd(1, 8'h3C, 1'b0);
        rd(0, 8'h83, 1'b1);
        rd(0, 8'h05, 1'b0);

        wr(0, 8'h13, 4'b0001, 3'b000, 1);
        check("reinit_done", init_done, 1'b0);
        wr(0, 8'h00, 4'b0000, 3'b000, 1);
        wr(1, 8'h20, 4'b0010, 3'b000, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        #1;
        check("rst_mid_outputs", {data_out, icw_stb, ocw_stb, init_done, poll_ack}, 17'h0);
        wr(1, 8'h55, 4'b0000, 3'b000, 1);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst  = ($urandom_range(0, 199) == 0);
            cs_n = ($urandom_range(0, 3) == 0);
            wr_n = ($urandom_range(0, 2) != 0);
            rd_n = ($urandom_range(0, 2) != 0);
            a0   = 1'($urandom);
            din  = 8'($urandom);
            if (!a0 && $urandom_range(0, 7) != 0) din[4] = 1'b0;
            irr = 8'($urandom); isr = 8'($urandom);
            imr = 8'($urandom); poll_word = 8'($urandom);
        end
        @(posedge clk); #1 rst = 0; idle();
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
